gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable self-test engine for the multi-function gate. It drives the gate's four inputs through all 16 combinations and samples the gate output F for each one. Each sample is compared against a caller-supplied 16-entry truth table, and the block reports pass/fail, the mismatch count, the first failing pattern and a full failure map. It sits beside the gate on the board and does in hardware what the simulation bench does in software, so lab hardware can be checked without a simulator.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: number of cycles each pattern is held before F is sampled. Legal range is 1..15.

Ports:
- clk, input, 1: the single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to run a sweep. Accepted only in IDLE.
- expected, input, 16: truth table. Bit i is the expected F for pattern i = {Y,X,B,A}. Latched when start is accepted.
- F, input, 1: output of the gate under test.
- A, B, X, Y, output, 1 each: registered stimulus to the gate. A is the LSB of the pattern index and toggles fastest.
- busy, output, 1: high from the cycle after start is accepted through the last SAMPLE cycle.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: 1 if the last sweep had zero mismatches.
- err_count, output, 5: mismatch count of the last sweep, 0..16.
- first_fail, output, 4: lowest failing pattern index. Reads 0 when pass=1.
- fail_map, output, 16: bit i set if pattern i mismatched.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Stimulus outputs hold their last value.
  - On start=1: latch expected, clear err_count, fail_map, first_fail and pass, set idx=0, go to SETTLE.
  - The outputs show pattern 0 from the next cycle.
- SETTLE: hold pattern idx for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Compare F against expected_q[idx].
  - On mismatch: set fail_map[idx] and increment err_count. If this is the first mismatch, load first_fail=idx.
  - If idx==15, go to DONE. Otherwise set idx=idx+1, drive the new pattern on the same edge, and go to SETTLE.
- DONE (1 cycle):
  - done=1.
  - pass is set to (err_count==0), valid from this cycle.
  - Then go to IDLE.
- Results (pass, err_count, first_fail, fail_map) hold until the next accepted start.
- Boundary conditions:
  - start outside IDLE, including during DONE, is ignored with no queuing.
  - Changes on expected after acceptance have no effect.
  - idx does not wrap; the sweep stops after pattern 15.
  - err_count cannot overflow (max 16 fits in 5 bits).
- Reset values: A=B=X=Y=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_map=0, state=IDLE.
- Reset mid-sweep aborts immediately and asynchronously. No partial results are retained.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE, and let S = SETTLE_CYCLES.
- Pattern i is driven during cycles 1+(S+1)i through (S+1)(i+1).
- F is sampled at the end of cycle (S+1)(i+1), i.e. F must be stable S+1 cycles after the pattern changes.
- done is high in cycle 16(S+1)+1. With the default S=2, this is cycle 49.
- busy is high in cycles 1..16(S+1), and low in the DONE cycle.
- All outputs are registered. There is no combinational path from F or start to any output.

## Structure
- Package gate_check_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE),
  - NUM_PATTERNS=16,
  - PAT_W=4,
  - ERR_W=5.
- Sub-module settle_timer is a loadable down-counter with a zero flag. It is parameterised by width and is reused by the FSM for the SETTLE dwell.
- Top level contains the FSM, the idx counter, the expected latch and the result registers.

## Test plan
- **AND gate model, clean:** gate model F=A&B&X&Y, expected=16'h8000, S=2.
  - Required: done in cycle 49, pass=1, err_count=0, fail_map=16'h0000, first_fail=0.
- **XOR gate model, F stuck-at-0:** expected=16'h6996, F tied to 0.
  - Required: err_count=8, fail_map=16'h6996, first_fail=1, pass=0.
- **Pattern ordering:** monitor {Y,X,B,A} during the sweep.
  - Required: the pattern equals i during cycles 1+3i..3+3i for i=0..15; A toggles every 3 cycles and Y every 24.
- **Ignored start:** pulse start at cycle 10, and change expected at cycle 12.
  - Required: done pulses exactly once, in cycle 49, with results matching the original expected.
- **Reset mid-sweep:** assert rst at cycle 20, between clock edges.
  - Required: all outputs go to 0 immediately. After release, start runs a fresh sweep that completes 49 cycles after acceptance.
- **Single settle cycle:** S=1 with the AND gate model.
  - Required: done in cycle 33, pass=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and sizes for the gate response checker.
package gate_check_pkg;

   // Sweep sequencing states.
   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int NUM_PATTERNS = 16;  // every combination of {Y,X,B,A}
   localparam int PAT_W        = 4;   // width of a pattern index
   localparam int ERR_W        = 5;   // holds 0..16 mismatches

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag, used to time the dwell on each
// stimulus pattern before the gate output is sampled.
module settle_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // Load wins over decrement; the count parks at zero rather than wrapping.
   // NOTE: state registers use non-blocking (<=) so every flop in the design
   // updates from pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Hardware self-test for the multi-function gate: sweeps all 16 input
// patterns, samples F after a settle dwell, and compares against a latched
// truth table, reporting pass/fail, mismatch count, first failure and a map.
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NUM_PATTERNS-1:0] expected,
   input  logic                    F,
   output logic                    A,
   output logic                    B,
   output logic                    X,
   output logic                    Y,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ERR_W-1:0]        err_count,
   output logic [PAT_W-1:0]        first_fail,
   output logic [NUM_PATTERNS-1:0] fail_map
);

   localparam int                 TIMER_W     = 4;
   // The SETTLE state lasts load+1 cycles, so load S-1 for an S-cycle dwell.
   localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [PAT_W-1:0]   LAST_IDX    = PAT_W'(NUM_PATTERNS - 1);

   state_t                  state_q, state_d;
   logic [PAT_W-1:0]        idx_q;
   logic [NUM_PATTERNS-1:0] expected_q;
   logic [ERR_W-1:0]        err_count_q;
   logic [PAT_W-1:0]        first_fail_q;
   logic [NUM_PATTERNS-1:0] fail_map_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    pass_q;

   logic accept;
   logic sample;
   logic timer_load;
   logic timer_dec;
   logic timer_zero;
   logic mismatch;

   settle_timer #(
      .WIDTH (TIMER_W)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      sample     = 1'b0;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (timer_zero) begin
               state_d = SAMPLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         SAMPLE: begin
            sample = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               timer_load = 1'b1;
               state_d    = SETTLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mismatch = (F != expected_q[idx_q]);

   // Pattern index, truth-table latch and result registers.
   // NOTE: the truth-table latch is reset along with the results so that an
   // aborted sweep leaves nothing behind; it costs one reset per flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= '0;
         expected_q   <= '0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         fail_map_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            idx_q        <= '0;
            expected_q   <= expected;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_map_q   <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
         end else if (sample) begin
            if (mismatch) begin
               fail_map_q[idx_q] <= 1'b1;
               err_count_q       <= err_count_q + ERR_W'(1);
               if (err_count_q == '0) begin
                  first_fail_q <= idx_q;
               end
            end
            if (idx_q == LAST_IDX) begin
               // Final sample: fold this compare into the verdict directly.
               busy_q <= 1'b0;
               done_q <= 1'b1;
               pass_q <= (err_count_q == '0) && !mismatch;
            end else begin
               idx_q <= idx_q + PAT_W'(1);
            end
         end
      end
   end

   // The stimulus is the index register itself; A is the LSB.
   assign A          = idx_q[0];
   assign B          = idx_q[1];
   assign X          = idx_q[2];
   assign Y          = idx_q[3];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign first_fail = first_fail_q;
   assign fail_map   = fail_map_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: two instances (settle 2 and
// settle 1) driven by software gate models, with a result scoreboard.
module tb_gate_response_checker;
   import gate_check_pkg::*;

   localparam int MODE_AND  = 0;
   localparam int MODE_STK0 = 1;
   localparam int MODE_XOR  = 2;

   typedef struct {
      logic [4:0]  err;
      logic [15:0] map;
      logic [3:0]  first;
      logic        pass;
   } result_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_v;
   logic        sel;
   logic [15:0] exp_v;
   int          gate_mode;

   logic        start0, f0, a0, b0, x0, y0, busy0, done0, pass0;
   logic [4:0]  err0;
   logic [3:0]  ff0;
   logic [15:0] map0;
   logic        start1, f1, a1, b1, x1, y1, busy1, done1, pass1;
   logic [4:0]  err1;
   logic [3:0]  ff1;
   logic [15:0] map1;

   logic [3:0]  obs_pat;
   logic        obs_busy, obs_done, obs_pass;
   logic [4:0]  obs_err;
   logic [3:0]  obs_first;
   logic [15:0] obs_map;

   result_t sb_q[$];
   int      total = 0;
   int      bad   = 0;

   always #5 clk = ~clk;

   function automatic logic gate_f(input int mode, input logic [3:0] p);
      case (mode)
         MODE_AND: return &p;
         MODE_XOR: return ^p;
         default:  return 1'b0;
      endcase
   endfunction

   assign f0     = gate_f(gate_mode, {y0, x0, b0, a0});
   assign f1     = gate_f(gate_mode, {y1, x1, b1, a1});
   assign start0 = start_v & ~sel;
   assign start1 = start_v & sel;

   assign obs_pat   = sel ? {y1, x1, b1, a1} : {y0, x0, b0, a0};
   assign obs_busy  = sel ? busy1 : busy0;
   assign obs_done  = sel ? done1 : done0;
   assign obs_pass  = sel ? pass1 : pass0;
   assign obs_err   = sel ? err1  : err0;
   assign obs_first = sel ? ff1   : ff0;
   assign obs_map   = sel ? map1  : map0;

   gate_response_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start0), .expected(exp_v), .F(f0),
      .A(a0), .B(b0), .X(x0), .Y(y0), .busy(busy0), .done(done0),
      .pass(pass0), .err_count(err0), .first_fail(ff0), .fail_map(map0)
   );

   gate_response_checker #(.SETTLE_CYCLES(1)) dut_s1 (
      .clk(clk), .rst(rst), .start(start1), .expected(exp_v), .F(f1),
      .A(a1), .B(b1), .X(x1), .Y(y1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1), .first_fail(ff1), .fail_map(map1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference result of a full sweep, computed pattern by pattern.
   function automatic result_t model(input logic [15:0] expt, input int mode);
      result_t r;
      r.err   = '0;
      r.map   = '0;
      r.first = '0;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] p;
         p = 4'(i);
         if (gate_f(mode, p) != expt[i]) begin
            if (r.err == 5'd0) r.first = p;
            r.map[i] = 1'b1;
            r.err    = r.err + 5'd1;
         end
      end
      r.pass = (r.err == 5'd0);
      return r;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_pat"},   32'(obs_pat),   0);
      check({tag, "_busy"},  32'(obs_busy),  0);
      check({tag, "_done"},  32'(obs_done),  0);
      check({tag, "_pass"},  32'(obs_pass),  0);
      check({tag, "_err"},   32'(obs_err),   0);
      check({tag, "_first"}, 32'(obs_first), 0);
      check({tag, "_map"},   32'(obs_map),   0);
   endtask

   // One sweep on the selected instance. With disturb set, start pulses at
   // cycle 10 and in the DONE cycle, and expected changes at cycles 10/12.
   task automatic run_sweep(input int s, input logic [15:0] expt, input bit disturb);
      int      per;
      int      done_cyc;
      int      dones;
      result_t r;
      per      = s + 1;
      done_cyc = 16 * per + 1;
      dones    = 0;
      @(negedge clk);
      start_v = 1'b1;
      exp_v   = expt;
      sb_q.push_back(model(expt, gate_mode));
      @(posedge clk);  // edge 0
      for (int k = 1; k <= done_cyc + 3; k++) begin
         @(negedge clk);  // inside cycle k
         start_v = 1'b0;
         if (disturb && k == 10) begin
            start_v = 1'b1;
            exp_v   = ~expt;
         end
         if (disturb && k == 12) exp_v = 16'h1234;
         if (disturb && k == done_cyc) start_v = 1'b1;
         if (k <= 16 * per) begin
            check("pattern", 32'(obs_pat), 32'((k - 1) / per));
            check("busy_on", 32'(obs_busy), 1);
         end else begin
            check("busy_off", 32'(obs_busy), 0);
         end
         if (obs_done) begin
            dones++;
            check("done_cycle", 32'(k), 32'(done_cyc));
            if (sb_q.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               r = sb_q.pop_front();
               check("pass",       32'(obs_pass),  32'(r.pass));
               check("err_count",  32'(obs_err),   32'(r.err));
               check("first_fail", 32'(obs_first), 32'(r.first));
               check("fail_map",   32'(obs_map),   32'(r.map));
            end
         end
      end
      start_v = 1'b0;
      check("done_pulses", 32'(dones), 1);
      check("sb_leftover", 32'(sb_q.size()), 0);
   endtask

   initial begin
      rst       = 1'b1;
      start_v   = 1'b0;
      sel       = 1'b0;
      exp_v     = 16'h0;
      gate_mode = MODE_AND;

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // AND gate, clean sweep, S=2.
      run_sweep(2, 16'h8000, 1'b0);
      check("and_pass",  32'(obs_pass),  1);
      check("and_err",   32'(obs_err),   0);
      check("and_map",   32'(obs_map),   32'h0000);
      check("and_first", 32'(obs_first), 0);

      // XOR table against a stuck-at-0 output.
      gate_mode = MODE_STK0;
      run_sweep(2, 16'h6996, 1'b0);
      check("xor_err",   32'(obs_err),   8);
      check("xor_map",   32'(obs_map),   32'h6996);
      check("xor_first", 32'(obs_first), 1);
      check("xor_pass",  32'(obs_pass),  0);

      // Healthy XOR gate against its own table.
      gate_mode = MODE_XOR;
      run_sweep(2, 16'h6996, 1'b0);

      // Ignored start / expected changes during a sweep and in DONE.
      gate_mode = MODE_AND;
      run_sweep(2, 16'h8000, 1'b1);
      check("ign_pass", 32'(obs_pass), 1);
      check("ign_map",  32'(obs_map),  32'h0000);

      // Reset mid-sweep at cycle 20, between edges.
      gate_mode = MODE_STK0;
      @(negedge clk);
      start_v = 1'b1;
      exp_v   = 16'h6996;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start_v = 1'b0;
      end
      check("pre_rst_busy", 32'(obs_busy), 1);
      check("pre_rst_err",  32'(obs_err),  3);
      check("pre_rst_pat",  32'(obs_pat),  6);
      #2 rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_rst");
      gate_mode = MODE_AND;
      run_sweep(2, 16'h8000, 1'b0);

      // Single settle cycle instance.
      sel = 1'b1;
      run_sweep(1, 16'h8000, 1'b0);
      check("s1_pass", 32'(obs_pass), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
